sigmoid_range_reducer: RTL
==========================

SIGMOID_RANGE_REDUCER -- requirements
Module: sigmoid_range_reducer

Interface
REQ-001 Parameter SIG_LATENCY, default 1: clock edges between a sig_x change and sig_f_x reflecting it; 0 means a combinational sigmoid core.
REQ-002 Parameter OUT_DEPTH, default 4: result FIFO depth; power of two, at least 2.
REQ-003 clk  in  1  single clock; all logic on the rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 in_valid  in  1  upstream sample valid.
REQ-006 in_ready  out  1  block can accept a sample.
REQ-007 in_x  in  16  signed Q5.10 input (1.0 = 1024).
REQ-008 sig_x  out  16  unsigned Q5.10 magnitude driven to the sigmoid core x port.
REQ-009 sig_f_x  in  16  unsigned Q0.10 result from the sigmoid core f_x port.
REQ-010 out_valid  out  1  result available.
REQ-011 out_ready  in  1  downstream accepts a result.
REQ-012 out_y  out  16  sign-restored sigmoid, 0..1024.
REQ-013 sat_count  out  16  count of clamped inputs (see Configuration).

Function
REQ-014 A sample is accepted at an edge where in_valid and in_ready are both high.
REQ-015 Magnitude rules: mag = |in_x|; -32768 maps to 32767; mag is clamped to 8192 (8.0); the sign is in_x[15].
REQ-016 sig_x is registered on accept and holds its value otherwise; it resets to 0.
REQ-017 A tag shift register, SIG_LATENCY+1 stages, carries {valid, sign, clamped} alongside each accept.
REQ-018 Sampling: for an accept at edge k, sig_f_x is sampled at edge k+1+SIG_LATENCY.
REQ-019 Before use, sig_f_x is clamped to 1024.
REQ-020 Sign restore: y = sign ? 1024 - f : f; the subtraction is unsigned 16-bit and never underflows after the clamp.
REQ-021 y is written to a show-ahead FIFO of OUT_DEPTH entries; out_valid = FIFO not empty; out_y = FIFO head.
REQ-022 A FIFO entry pops at an edge where out_valid and out_ready are both high.
REQ-023 Minimum latency is SIG_LATENCY+2 edges from accept to out_valid high.
REQ-024 Credit rule: in_ready = (in_flight + fifo_count) < OUT_DEPTH, where in_flight is the number of valid tags.
REQ-025 The credit rule guarantees the FIFO never overflows and no result is dropped.
REQ-026 A pop in the same cycle as a FIFO write is legal; the count is unchanged.
REQ-027 in_ready is combinational from registered state only; it does not depend on in_valid or out_ready.
REQ-028 Results leave in acceptance order.
REQ-029 out_y is held stable while out_valid is high and out_ready is low.

Reset
REQ-030 While reset is high: in_ready=0, out_valid=0, out_y=0, sig_x=0, sat_count=0; tags and FIFO pointers clear.
REQ-031 Reset mid-operation discards all in-flight and buffered results.
REQ-032 In the first cycle after reset deasserts, in_ready=1.

Configuration
REQ-033 With SIGMOID_SAT_CNT_EN defined, sat_count increments on each accept whose clamped bit is set, saturating at 65535.
REQ-034 Without SIGMOID_SAT_CNT_EN, sat_count is tied to 0 and no counter logic is synthesized.

Structure
REQ-035 Shared package sigmoid_pkg holds:
- constants FRAC_W=10, ONE_Q=1024, CLAMP_MAG=8192
- typedef q5_10_t (16-bit)
- packed struct sig_tag_t {valid, sign, clamped}
REQ-036 The FIFO is a sub-module, sigmoid_res_fifo, with parameters WIDTH and DEPTH and ports push/pop/full/empty/count.
REQ-037 The sigmoid core is not instantiated inside this block; it connects externally via sig_x and sig_f_x.

Verification
REQ-038 Bench drives a behavioural core model of SIG_LATENCY=1 plus this block.
REQ-039 in_x=0, core returns 512 -> sig_x=0, out_y=512, out_valid high 3 edges after accept.
REQ-040 in_x=-2048 (-2.0), core returns 901 -> sig_x=2048, out_y=123.
REQ-041 in_x=16384 and in_x=-32768, core returns 1024 for 8192 -> sig_x=8192 both times, out_y=1024 then 0; sat_count=2 with the macro, 0 without.
REQ-042 Core returns 1100 for a positive sample -> out_y=1024; for a negative sample -> out_y=0.
REQ-043 out_ready=0, 6 samples offered back to back -> exactly 4 accepted and in_ready low; then out_ready=1 -> 4 results in order, then the remaining 2 accepted.
REQ-044 Reset pulsed with 2 in flight and 1 buffered -> out_valid=0 the next cycle, no stale result appears, and in_ready=1 once reset is low.

Source files
------------

// File: rtl/sigmoid_pkg.sv
// Shared constants, types and helpers for the sigmoid range reducer.
// Fixed-point convention: Q5.10 input/magnitude, Q0.10 sigmoid result.
package sigmoid_pkg;

  localparam int FRAC_W = 10;

  typedef logic [15:0] q5_10_t;

  localparam q5_10_t ONE_Q     = q5_10_t'(1 << FRAC_W);
  localparam q5_10_t CLAMP_MAG = q5_10_t'(8 << FRAC_W);

  typedef struct packed {
    logic valid;
    logic sign;
    logic clamped;
  } sig_tag_t;

  // Absolute value of a signed Q5.10 word; the most negative code folds to +max.
  function automatic q5_10_t abs_mag(input q5_10_t x);
    if (x == 16'h8000) begin
      return 16'h7FFF;
    end else if (x[15]) begin
      return -x;
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/sigmoid_res_fifo.sv
// Show-ahead result FIFO: rdata always presents the oldest entry while not empty.
// The caller guarantees push is never asserted while full.
module sigmoid_res_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_pop;

  always_comb begin
    do_pop = pop && !empty;
    wr_d   = push ? wr_q + 1'b1 : wr_q;
    rd_d   = do_pop ? rd_q + 1'b1 : rd_q;
    count  = wr_q - rd_q;
    empty  = (wr_q == rd_q);
    full   = (count == (AW+1)'(DEPTH));
    rdata  = mem_q[rd_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/sigmoid_range_reducer.sv
// Folds a signed Q5.10 sample onto [0, 8.0] for an external sigmoid core and
// restores the sign on the result. Optional clamp counter: SIGMOID_SAT_CNT_EN.
module sigmoid_range_reducer
  import sigmoid_pkg::*;
#(
  parameter int SIG_LATENCY = 1,
  parameter int OUT_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_x,
  output logic [15:0] sig_x,
  input  logic [15:0] sig_f_x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_y,
  output logic [15:0] sat_count
);

  localparam int TAGS = SIG_LATENCY + 1;
  localparam int CW   = $clog2(OUT_DEPTH) + 1;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready is derived from registered credit state only.
  q5_10_t         mag;
  logic           clamp_hit;
  logic           accept;
  q5_10_t         sig_x_q, sig_x_d;
  sig_tag_t       tag_q [TAGS];
  sig_tag_t       tag_in;
  logic [15:0]    in_flight;
  q5_10_t         f_clamped;
  q5_10_t         y;
  logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]  fifo_count;
  q5_10_t         fifo_head;

  always_comb begin
    mag       = abs_mag(in_x);
    clamp_hit = (mag > CLAMP_MAG);
    accept    = in_valid && in_ready;
    sig_x_d   = sig_x_q;
    if (accept) begin
      sig_x_d = clamp_hit ? CLAMP_MAG : mag;
    end
    tag_in.valid   = accept;
    tag_in.sign    = in_x[15];
    tag_in.clamped = clamp_hit;
  end

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < TAGS; i++) begin
      in_flight = in_flight + 16'(tag_q[i].valid);
    end
  end

  // Credits cover both results still in the core pipe and results buffered.
  assign in_ready = !reset && ((in_flight + 16'(fifo_count)) < 16'(OUT_DEPTH));
  assign sig_x    = sig_x_q;

  always_comb begin
    f_clamped = (sig_f_x > ONE_Q) ? ONE_Q : sig_f_x;
    y         = tag_q[SIG_LATENCY].sign ? (ONE_Q - f_clamped) : f_clamped;
    fifo_push = tag_q[SIG_LATENCY].valid && !fifo_full;
    out_valid = !reset && !fifo_empty;
    fifo_pop  = out_valid && out_ready;
    out_y     = out_valid ? fifo_head : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sig_x_q <= '0;
      for (int i = 0; i < TAGS; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      sig_x_q  <= sig_x_d;
      tag_q[0] <= tag_in;
      for (int i = 1; i < TAGS; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  sigmoid_res_fifo #(
    .WIDTH (16),
    .DEPTH (OUT_DEPTH)
  ) u_res_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (y),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef SIGMOID_SAT_CNT_EN
  logic [15:0] sat_q, sat_d;

  always_comb begin
    sat_d = sat_q;
    if (accept && clamp_hit && (sat_q != 16'hFFFF)) begin
      sat_d = sat_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sat_q <= '0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign sat_count = sat_q;
`else
  assign sat_count = '0;
`endif

endmodule
